ac_control: RTL and testbench

//   Accumulator (AC) control/decode for the 16-bit MIPS-style datapath.

---
 rtl/ac_control.sv | 89 ++++++++
 tb/tb_ac_control.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ac_control.sv
// Accumulator control/decode: priority-decodes the instruction control bits into
// the AC source select and write enable, and owns the AC register plus a sticky illegal flag.
module ac_control #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump,
    input  logic             jumpC,
    input  logic             sin,
    input  logic             InA,
    input  logic             twone,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] in_data,
    output logic             saidaMux,
    output logic             saidaAc,
    output logic [WIDTH-1:0] ac_q,
    output logic             illegal
);

    logic             any_jump_s;
    logic             alu_op_s;
    logic             illegal_now_s;
    logic [WIDTH-1:0] ac_d;
    logic             illegal_d;
    logic             illegal_q;

    // Priority decode of the control bits; jumps win so they never disturb AC.
    always_comb begin
        any_jump_s = jump | jumpC;
        alu_op_s   = sin | twone;
        saidaMux   = 1'b0;
        saidaAc    = 1'b0;
        if (any_jump_s) begin
            saidaMux = 1'b0;
            saidaAc  = 1'b0;
        end else if (InA) begin
            saidaMux = 1'b1;
            saidaAc  = 1'b1;
        end else if (alu_op_s) begin
            saidaMux = 1'b0;
            saidaAc  = 1'b1;
        end else begin
            saidaMux = 1'b0;
            saidaAc  = 1'b0;
        end
    end

    // Mutually exclusive instruction classes asserted together; sin with twone is allowed.
    always_comb begin
        illegal_now_s = (jump & jumpC)
                      | ((jump | jumpC) & (sin | InA | twone))
                      | (InA & (sin | twone));
    end

    // Next-state for the accumulator and the sticky flag.
    always_comb begin
        ac_d      = ac_q;
        illegal_d = illegal_q;
        if (saidaAc) begin
            if (saidaMux) begin
                ac_d = in_data;
            end else begin
                ac_d = alu_result;
            end
        end else begin
            ac_d = ac_q;
        end
        if (illegal_now_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // State registers; reset takes precedence over any load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q      <= {WIDTH{1'b0}};
            illegal_q <= 1'b0;
        end else begin
            ac_q      <= ac_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_ac_control.sv
// Directed plus random bench for ac_control; expected register state is queued
// when each step is driven and compared after the following clock edge.
module tb_ac_control;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] ac;
        logic             ill;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             jump;
    logic             jumpC;
    logic             sin;
    logic             InA;
    logic             twone;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] in_data;
    logic             saidaMux;
    logic             saidaAc;
    logic [WIDTH-1:0] ac_q;
    logic             illegal;

    int               n_checks;
    int               n_fails;
    exp_t             sb_q[$];
    logic [WIDTH-1:0] model_ac;
    logic             model_ill;

    ac_control #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .jump       (jump),
        .jumpC      (jumpC),
        .sin        (sin),
        .InA        (InA),
        .twone      (twone),
        .alu_result (alu_result),
        .in_data    (in_data),
        .saidaMux   (saidaMux),
        .saidaAc    (saidaAc),
        .ac_q       (ac_q),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One directed step: drive on the falling edge, check decode, queue and check state.
    task automatic step(input string tag, input logic r, input logic [4:0] ctl,
                        input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] din);
        logic j, jc, s, ia, tw, en, mx, bad;
        exp_t e, got;
        {j, jc, s, ia, tw} = ctl;
        @(negedge clk);
        rst = r; jump = j; jumpC = jc; sin = s; InA = ia; twone = tw;
        alu_result = alu; in_data = din;
        #1;
        en  = !(j || jc) && (ia || s || tw);
        mx  = !(j || jc) && ia;
        bad = (j && jc) || ((j || jc) && (s || ia || tw)) || (ia && (s || tw));
        chk({tag, ".mux"}, {15'd0, saidaMux}, {15'd0, mx});
        chk({tag, ".wen"}, {15'd0, saidaAc}, {15'd0, en});
        if (r) begin
            model_ac  = 16'h0000;
            model_ill = 1'b0;
        end else begin
            if (en) model_ac = mx ? din : alu;
            if (bad) model_ill = 1'b1;
        end
        e.ac  = model_ac;
        e.ill = model_ill;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'd1, 16'd0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, ".ac_q"}, ac_q, got.ac);
            chk({tag, ".illegal"}, {15'd0, illegal}, {15'd0, got.ill});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        model_ac = 16'h0000;
        model_ill = 1'b0;
        rst = 1'b1; jump = 1'b0; jumpC = 1'b0; sin = 1'b0; InA = 1'b0; twone = 1'b0;
        alu_result = 16'h0000; in_data = 16'h0000;

        // ctl order: {jump, jumpC, sin, InA, twone}
        step("reset",       1'b1, 5'b00000, 16'hFFFF, 16'hFFFF);
        step("load_in",     1'b0, 5'b00010, 16'h1111, 16'hBEEF);
        step("idle_hold",   1'b0, 5'b00000, 16'h2222, 16'h3333);
        step("jump",        1'b0, 5'b10000, 16'h5555, 16'h6666);
        step("jumpc",       1'b0, 5'b01000, 16'h7777, 16'h8888);
        step("sin",         1'b0, 5'b00100, 16'h1234, 16'h9999);
        step("twone",       1'b0, 5'b00001, 16'h4321, 16'hAAAA);
        step("sin_twone",   1'b0, 5'b00101, 16'h1234, 16'hBBBB);
        step("both_jumps",  1'b0, 5'b11000, 16'hCCCC, 16'hDDDD);
        step("sticky",      1'b0, 5'b00000, 16'hEEEE, 16'hFFFF);
        step("rst_clear",   1'b1, 5'b00000, 16'h0F0F, 16'hF0F0);
        step("ina_twone",   1'b0, 5'b00011, 16'h5A5A, 16'hA5A5);
        step("ina_tw_hold", 1'b0, 5'b00000, 16'h0001, 16'h0002);
        step("rst_with_ina",1'b1, 5'b00010, 16'h1357, 16'h2468);
        step("jump_sin",    1'b0, 5'b10100, 16'hDEAD, 16'hFACE);
        step("rst2",        1'b1, 5'b00000, 16'h0000, 16'h0000);
        step("full_width",  1'b0, 5'b00100, 16'h8001, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] c;
            logic       r;
            c = 5'($urandom_range(0, 31));
            r = ($urandom_range(0, 9) == 0);
            step("rand", r, c, 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
